// File: rtl/apb3_cmd_master.sv
// -----------------------------------------------------------------------------
// apb3_cmd_master
//
// APB3 initiator that accepts single-beat commands on a valid/ready command
// channel, runs one APB3 SETUP/ACCESS transfer per command, and returns the
// result on a valid/ready response channel. An ACCESS-phase wait-state
// counter aborts transfers to a slave that never raises PREADY.
//
// Ports
//   PCLK, PRESETN          clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY    command handshake
//   CMD_ADDR/WRITE/WDATA   command payload
//   RSP_VALID/RSP_READY    response handshake
//   RSP_RDATA              read data (0 for writes and timeouts)
//   RSP_SLVERR             captured PSLVERR, forced 1 on timeout
//   RSP_TIMEOUT            transfer aborted by the wait-state timeout
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB master outputs
//   PRDATA/PREADY/PSLVERR  APB slave returns
//   BUSY                   high whenever the FSM is not IDLE
//
// TIMEOUT_CYCLES = 0 disables the timeout; otherwise it must fit in
// TIMEOUT_WIDTH bits.
// -----------------------------------------------------------------------------
module apb3_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic                  CMD_WRITE,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_SLVERR,
  output logic                  RSP_TIMEOUT,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Counter value on the last permitted wait-state cycle. When the timeout
  // is disabled this wraps to all-ones, but it is never consulted.
  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX  = '1;

  state_t                   state;
  state_t                   state_next;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic                     timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state <= IDLE;
    else          state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. PREADY is tested before the timeout so a slave that
  // answers on the final permitted cycle still completes normally.
  // ---------------------------------------------------------------------------
  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (CMD_VALID) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_next = RESP;
      RESP:    if (RSP_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control outputs decode from the registered state only, so nothing on the
  // command or APB inputs can reach an output combinationally.
  // ---------------------------------------------------------------------------
  assign CMD_READY = (state == IDLE);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign RSP_VALID = (state == RESP);
  assign BUSY      = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: command latch, wait-state counter, response capture.
  // The APB payload is only written in IDLE, so it cannot move while PSEL is
  // high, and it stays put after the transfer until the next accept.
  // Response fields are only written in ACCESS and therefore survive the
  // response handshake.
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset here; these are plain flops, not
  // a memory array, so the reset costs nothing and gives defined outputs.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      wait_cnt    <= '0;
      RSP_RDATA   <= '0;
      RSP_SLVERR  <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            PADDR    <= CMD_ADDR;
            PWRITE   <= CMD_WRITE;
            PWDATA   <= CMD_WDATA;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            RSP_RDATA   <= PWRITE ? '0 : PRDATA;
            RSP_SLVERR  <= PSLVERR;
            RSP_TIMEOUT <= 1'b0;
          end else if (timeout_hit) begin
            RSP_RDATA   <= '0;
            RSP_SLVERR  <= 1'b1;
            RSP_TIMEOUT <= 1'b1;
          end else if (wait_cnt != WAIT_MAX) begin
            // Saturate rather than wrap so a disabled timeout never
            // rolls the counter over.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
